fib_producer: RTL and testbench

FIB_PRODUCER -- requirements
Module: fib_producer

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_producer.sv | 102 ++++++++++
 tb/tb_fib_producer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci producer: state encoding and sequence constants.
package fib_pkg;

  localparam int FIB_WIDTH     = 16;
  localparam int FIB_NUM_TERMS = 25;
  localparam int FIB_LAST_TERM = 46368;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fib_producer.sv
// Fibonacci term producer feeding a downstream CDC buffer, one term per cycle
// under buffer_full backpressure, with start/stop control.
//
// Write handshake: data_1 is valid while busy; a transfer happens on every
// rising clk_1 edge where data_1_en=1, and data_1_en is never high while
// buffer_full=1, stop=1 or rst=1.
module fib_producer
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             buffer_full,
  output logic             data_1_en,
  output logic [WIDTH-1:0] data_1,
  output logic             busy,
  output logic             done,
  output logic [4:0]       term_count,
  output state_t           dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH:0]   r_b;
  logic [4:0]       r_term_count;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH:0]   w_b_nxt;
  logic [4:0]       w_term_count_nxt;
  logic             w_wr;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= {{WIDTH{1'b0}}, 1'b1};
      r_term_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_term_count <= w_term_count_nxt;
    end
  end

  always_comb begin
    w_wr             = (r_state == ST_RUN) && !buffer_full && !stop && !rst;
    w_state_nxt      = r_state;
    w_a_nxt          = r_a;
    w_b_nxt          = r_b;
    w_term_count_nxt = r_term_count;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (start) begin
          w_state_nxt      = ST_RUN;
          w_a_nxt          = '0;
          w_b_nxt          = {{WIDTH{1'b0}}, 1'b1};
          w_term_count_nxt = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (buffer_full) begin
          w_state_nxt = ST_STALL;
        end else begin
          w_term_count_nxt = r_term_count + 5'd1;
          // b overflowing 16 bits means a holds the last representable term.
          if (r_b[WIDTH]) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_a_nxt = r_b[WIDTH-1:0];
            w_b_nxt = {1'b0, r_a} + r_b;
          end
        end
      end
      ST_STALL: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (!buffer_full) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are forced to zero while rst is asserted.
  assign data_1_en  = w_wr;
  assign data_1     = rst ? '0 : r_a;
  assign busy       = !rst && ((r_state == ST_RUN) || (r_state == ST_STALL));
  assign done       = !rst && (r_state == ST_DONE);
  assign term_count = rst ? '0 : r_term_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fib_producer.sv
// Bench for fib_producer: directed scenarios push expected terms into a queue,
// a negedge monitor pops and compares on every write strobe.
module tb_fib_producer;
  import fib_pkg::*;

  logic        clk_1;
  logic        rst;
  logic        start;
  logic        stop;
  logic        buffer_full;
  logic        data_1_en;
  logic [15:0] data_1;
  logic        busy;
  logic        done;
  logic [4:0]  term_count;
  state_t      dbg_state;

  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_errors;
  logic [15:0] fib_tab [25];

  fib_producer #(.WIDTH(16)) dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .buffer_full (buffer_full),
    .data_1_en   (data_1_en),
    .data_1      (data_1),
    .busy        (busy),
    .done        (done),
    .term_count  (term_count),
    .dbg_state   (dbg_state)
  );

  // clock/reset block
  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk_1);
      #1;
    end
  endtask

  task automatic push_terms(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(fib_tab[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(2);
    check("rst_en",    16'(data_1_en),  16'd0);
    check("rst_data",  data_1,          16'd0);
    check("rst_busy",  16'(busy),       16'd0);
    check("rst_done",  16'(done),       16'd0);
    check("rst_count", 16'(term_count), 16'd0);
    rst = 1'b0;
    cycle(1);
    check("post_rst_data",  data_1,          16'd0);
    check("post_rst_count", 16'(term_count), 16'd0);
    check("post_rst_state", 16'(dbg_state),  16'(ST_IDLE));
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"},  16'(done),       16'd1);
    check({tag, "_busy"},  16'(busy),       16'd0);
    check({tag, "_count"}, 16'(term_count), 16'd25);
    check({tag, "_data"},  data_1,          16'd46368);
    check({tag, "_en"},    16'(data_1_en),  16'd0);
    check({tag, "_drain"}, 16'(exp_q.size()), 16'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk_1) begin
    if (data_1_en) begin
      check("wr_while_full", 16'(buffer_full), 16'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got %0d expected no write at %0t", data_1, $time);
      end else begin
        check("term", data_1, exp_q.pop_front());
      end
    end
  end

  initial begin
    int guard;
    fib_tab = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
                16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610,
                16'd987, 16'd1597, 16'd2584, 16'd4181, 16'd6765, 16'd10946,
                16'd17711, 16'd28657, 16'd46368};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    buffer_full = 1'b0;

    // Free-running run: 25 consecutive writes, then DONE holds.
    do_reset();
    push_terms(25);
    pulse_start();
    check("first_busy", 16'(busy), 16'd1);
    cycle(25);
    check_done("run1");
    cycle(3);
    check_done("run1_hold");

    // Restart from DONE.
    push_terms(25);
    pulse_start();
    check("restart_done",  16'(done),       16'd0);
    check("restart_count", 16'(term_count), 16'd0);
    check("restart_data",  data_1,          16'd0);
    cycle(25);
    check_done("run2");

    // Three cycles of backpressure after the 4th write.
    do_reset();
    push_terms(25);
    pulse_start();
    cycle(4);
    buffer_full = 1'b1;
    cycle(3);
    check("stall_data",  data_1,          16'd3);
    check("stall_count", 16'(term_count), 16'd4);
    check("stall_busy",  16'(busy),       16'd1);
    check("stall_state", 16'(dbg_state),  16'(ST_STALL));
    buffer_full = 1'b0;
    cycle(1);
    cycle(21);
    check_done("bp");

    // Stop after 10 writes, then restart.
    do_reset();
    push_terms(10);
    pulse_start();
    cycle(10);
    stop = 1'b1;
    cycle(1);
    stop = 1'b0;
    check("stop_busy",  16'(busy),       16'd0);
    check("stop_count", 16'(term_count), 16'd10);
    check("stop_data",  data_1,          16'd55);
    cycle(5);
    check("stop_hold_count", 16'(term_count), 16'd10);
    push_terms(25);
    pulse_start();
    check("rerun_data",  data_1,          16'd0);
    check("rerun_count", 16'(term_count), 16'd0);
    cycle(25);
    check_done("rerun");

    // stop from DONE, then start+stop together in IDLE.
    stop = 1'b1;
    cycle(1);
    stop = 1'b0;
    check("done_stop_done", 16'(done), 16'd0);
    start = 1'b1;
    stop = 1'b1;
    cycle(1);
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy",  16'(busy),      16'd0);
    check("ss_state", 16'(dbg_state), 16'(ST_IDLE));
    cycle(3);
    check("ss_busy_later", 16'(busy), 16'd0);

    // Reset on the cycle of the 7th write.
    do_reset();
    push_terms(6);
    pulse_start();
    cycle(6);
    rst = 1'b1;
    #1;
    check("rst_mid_en", 16'(data_1_en), 16'd0);
    cycle(1);
    rst = 1'b0;
    check("rst_mid_en_after", 16'(data_1_en),  16'd0);
    check("rst_mid_data",     data_1,          16'd0);
    check("rst_mid_busy",     16'(busy),       16'd0);
    check("rst_mid_done",     16'(done),       16'd0);
    check("rst_mid_count",    16'(term_count), 16'd0);
    check("rst_mid_state",    16'(dbg_state),  16'(ST_IDLE));
    check("rst_mid_drain",    16'(exp_q.size()), 16'd0);
    cycle(3);
    check("rst_mid_idle", 16'(busy), 16'd0);

    // Random backpressure over a full run.
    do_reset();
    push_terms(25);
    pulse_start();
    guard = 0;
    while (!done && guard < 400) begin
      buffer_full = 1'($urandom_range(0, 1));
      cycle(1);
      guard++;
    end
    buffer_full = 1'b0;
    check("rand_timeout", 16'(guard < 400), 16'd1);
    check_done("rand");

    cycle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
